// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: the ID-stage instruction fields going in, and
// the issue/stall decision plus bypass selection coming back out.
interface hazard_if #(
  parameter int MUL_LAT = 4,
  parameter int FWD_WIN = 2
);
  localparam int CW = $clog2(MUL_LAT + FWD_WIN);

  logic          id_valid;
  logic [4:0]    id_src_reg_1;
  logic          id_uses_src1;
  logic [4:0]    id_src_reg_2;
  logic          id_uses_src2;
  logic [4:0]    id_dst_reg;
  logic          id_reg_we;
  logic          id_is_load;
  logic          id_is_mul;
  logic          id_flush;

  logic          stall;
  logic          issue;
  logic          dep_src1;
  logic          dep_src2;
  logic [CW-1:0] fwd_sel1;
  logic [CW-1:0] fwd_sel2;

  modport master (
    output id_valid, id_src_reg_1, id_uses_src1, id_src_reg_2, id_uses_src2,
           id_dst_reg, id_reg_we, id_is_load, id_is_mul, id_flush,
    input  stall, issue, dep_src1, dep_src2, fwd_sel1, fwd_sel2
  );

  modport slave (
    input  id_valid, id_src_reg_1, id_uses_src1, id_src_reg_2, id_uses_src2,
           id_dst_reg, id_reg_we, id_is_load, id_is_mul, id_flush,
    output stall, issue, dep_src1, dep_src2, fwd_sel1, fwd_sel2
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard between ID and EXE. Each architectural register
// has a countdown of cycles until its pending write leaves the bypass window
// and is visible in the register file. Sources inside the bypass window are
// forwarded (fwd_sel = remaining count); sources further out stall issue.
// A new write to a register whose older write would land later also stalls,
// so writes always retire in program order.
module hazard_scoreboard #(
  parameter int REG_FILE_LEN = 32,
  parameter int ALU_LAT      = 1,
  parameter int LOAD_LAT     = 2,
  parameter int MUL_LAT      = 4,
  parameter int FWD_WIN      = 2
) (
  input  logic    clk,
  input  logic    rst,
  hazard_if.slave hz
);
  localparam int CW = $clog2(MUL_LAT + FWD_WIN);

  // Reload values: producer latency plus the forwarding window, minus the
  // cycle already spent in the issue edge.
  localparam logic [CW-1:0] L_ALU   = CW'(ALU_LAT + FWD_WIN - 1);
  localparam logic [CW-1:0] L_LOAD  = CW'(LOAD_LAT + FWD_WIN - 1);
  localparam logic [CW-1:0] L_MUL   = CW'(MUL_LAT + FWD_WIN - 1);
  localparam logic [CW-1:0] FWD_MAX = CW'(FWD_WIN);

  // Entry 0 is never loaded (rd = 0 is excluded from wr_en), so x0 stays idle.
  logic [REG_FILE_LEN-1:0][CW-1:0] cnt_reg;
  logic [REG_FILE_LEN-1:0][CW-1:0] cnt_next;

  logic [CW-1:0] load_val;
  logic [CW-1:0] cnt_src1;
  logic [CW-1:0] cnt_src2;
  logic [CW-1:0] cnt_dst;
  logic          use1;
  logic          use2;
  logic          raw1;
  logic          raw2;
  logic          waw;
  logic          dep1;
  logic          dep2;
  logic          stall_int;
  logic          issue_int;
  logic          wr_en;

  // Reload value chosen by producer class, MUL over LOAD over ALU
  always_comb begin
    if (hz.id_is_mul) begin
      load_val = L_MUL;
    end else if (hz.id_is_load) begin
      load_val = L_LOAD;
    end else begin
      load_val = L_ALU;
    end
  end

  // Classify each source and the destination against the pre-edge counts
  always_comb begin
    cnt_src1  = cnt_reg[hz.id_src_reg_1];
    cnt_src2  = cnt_reg[hz.id_src_reg_2];
    cnt_dst   = cnt_reg[hz.id_dst_reg];

    use1      = hz.id_uses_src1 && (hz.id_src_reg_1 != 5'd0);
    use2      = hz.id_uses_src2 && (hz.id_src_reg_2 != 5'd0);

    // Result not yet on the bypass bus: must wait.
    raw1      = use1 && (cnt_src1 > FWD_MAX);
    raw2      = use2 && (cnt_src2 > FWD_MAX);

    // Result is somewhere in the bypass network: forward it.
    dep1      = hz.id_valid && use1 && (cnt_src1 != '0) && (cnt_src1 <= FWD_MAX);
    dep2      = hz.id_valid && use2 && (cnt_src2 != '0) && (cnt_src2 <= FWD_MAX);

    // An older write that would land after this one must go first.
    waw       = hz.id_reg_we && (hz.id_dst_reg != 5'd0) && (cnt_dst > load_val);

    stall_int = hz.id_valid && (raw1 || raw2 || waw);
    issue_int = hz.id_valid && !stall_int && !hz.id_flush;
    wr_en     = issue_int && hz.id_reg_we && (hz.id_dst_reg != 5'd0);
  end

  assign hz.stall    = stall_int;
  assign hz.issue    = issue_int;
  assign hz.dep_src1 = dep1;
  assign hz.dep_src2 = dep2;
  assign hz.fwd_sel1 = dep1 ? cnt_src1 : '0;
  assign hz.fwd_sel2 = dep2 ? cnt_src2 : '0;

  // Per-register next count: reload on an issuing write, else count down to 0
  for (genvar gi = 0; gi < REG_FILE_LEN; gi++) begin : g_cnt
    assign cnt_next[gi] = (wr_en && (hz.id_dst_reg == 5'(gi))) ? load_val :
                          (cnt_reg[gi] != '0)                 ? cnt_reg[gi] - CW'(1) :
                                                                 '0;
  end

  // Countdown state; reset drops every pending write immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a hand-computed cycle table from reset, an
// asynchronous reset corner sequence, then random traffic checked against a
// model that tracks the absolute cycle at which each register becomes ready.
module tb_hazard_scoreboard;
  localparam int FWD_WIN = 2;
  localparam int L_ALU   = 1 + FWD_WIN - 1;
  localparam int L_LOAD  = 2 + FWD_WIN - 1;
  localparam int L_MUL   = 4 + FWD_WIN - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_if hz ();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mul;
    logic       flush;
    logic [9:0] exp;   // {stall, issue, dep1, dep2, sel1[2:0], sel2[2:0]}
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: absolute cycle at which each register's write is visible
  // in the register file; remaining = ready_at - now.
  int unsigned ready_at[32];
  int unsigned now = 0;

  function automatic vec_t r(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic we,
                             input logic ld, input logic mul, input logic fl,
                             input logic st, input logic is, input logic d1,
                             input logic d2, input logic [2:0] s1, input logic [2:0] s2);
    vec_t x;
    x.valid = v;  x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    x.rd = rd;    x.we = we;   x.ld = ld; x.mul = mul; x.flush = fl;
    x.exp = {st, is, d1, d2, s1, s2};
    return x;
  endfunction

  task automatic drive(input vec_t x);
    hz.id_valid     = x.valid;
    hz.id_src_reg_1 = x.rs1;
    hz.id_uses_src1 = x.u1;
    hz.id_src_reg_2 = x.rs2;
    hz.id_uses_src2 = x.u2;
    hz.id_dst_reg   = x.rd;
    hz.id_reg_we    = x.we;
    hz.id_is_load   = x.ld;
    hz.id_is_mul    = x.mul;
    hz.id_flush     = x.flush;
  endtask

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = {hz.stall, hz.issue, hz.dep_src1, hz.dep_src2, hz.fwd_sel1, hz.fwd_sel2};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got stall=%0b issue=%0b dep=%0b%0b sel=%0d/%0d, required stall=%0b issue=%0b dep=%0b%0b sel=%0d/%0d",
               name, got[9], got[8], got[7], got[6], got[5:3], got[2:0],
               exp[9], exp[8], exp[7], exp[6], exp[5:3], exp[2:0]);
    end
  endtask

  function automatic int unsigned rem(input logic [4:0] reg_idx);
    if (reg_idx == 5'd0) return 0;
    return (ready_at[reg_idx] > now) ? ready_at[reg_idx] - now : 0;
  endfunction

  initial begin
    vec_t idle;
    vec_t v;
    idle = r(0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0,0,0);

    //        v  rs1 u1 rs2 u2 rd we ld mul fl | st is d1 d2 s1 s2
    tbl.push_back(r(0,  0,0,  0,0,  0,0, 0,0,0,  0,0,0,0,0,0)); // 0 idle after reset
    tbl.push_back(r(1,  0,0,  0,0,  5,1, 0,0,0,  0,1,0,0,0,0)); // 1 ALU -> x5
    tbl.push_back(r(1,  5,1,  0,0,  0,0, 0,0,0,  0,1,1,0,2,0)); // 2 read x5 forwarded
    tbl.push_back(r(1,  0,0,  0,0,  6,1, 1,0,0,  0,1,0,0,0,0)); // 3 LOAD -> x6
    tbl.push_back(r(1,  0,0,  6,1,  0,0, 0,0,0,  1,0,0,0,0,0)); // 4 read x6: stall
    tbl.push_back(r(1,  0,0,  6,1,  0,0, 0,0,0,  0,1,0,1,0,2)); // 5 read x6 fwd 2
    tbl.push_back(r(0,  0,0,  0,0,  0,0, 0,0,0,  0,0,0,0,0,0)); // 6 bubble
    tbl.push_back(r(1,  6,1,  0,0,  0,0, 0,0,0,  0,1,0,0,0,0)); // 7 x6 from regfile
    tbl.push_back(r(1,  0,0,  0,0,  7,1, 0,1,0,  0,1,0,0,0,0)); // 8 MUL -> x7
    tbl.push_back(r(1,  7,1,  0,0,  0,0, 0,0,0,  1,0,0,0,0,0)); // 9 stall
    tbl.push_back(r(1,  7,1,  0,0,  0,0, 0,0,0,  1,0,0,0,0,0)); // 10 stall
    tbl.push_back(r(1,  7,1,  0,0,  0,0, 0,0,0,  1,0,0,0,0,0)); // 11 stall
    tbl.push_back(r(1,  7,1,  0,0,  0,0, 0,0,0,  0,1,1,0,2,0)); // 12 issue fwd 2
    tbl.push_back(r(1,  0,0,  0,0,  8,1, 0,1,0,  0,1,0,0,0,0)); // 13 MUL -> x8
    tbl.push_back(r(1,  0,0,  0,0,  8,1, 0,0,0,  1,0,0,0,0,0)); // 14 ALU x8 WAW
    tbl.push_back(r(1,  0,0,  0,0,  8,1, 0,0,0,  1,0,0,0,0,0)); // 15 WAW
    tbl.push_back(r(1,  0,0,  0,0,  8,1, 0,0,0,  1,0,0,0,0,0)); // 16 WAW
    tbl.push_back(r(1,  0,0,  0,0,  8,1, 0,0,0,  0,1,0,0,0,0)); // 17 cnt=2 issues
    tbl.push_back(r(1,  8,1,  8,1,  0,0, 0,0,0,  0,1,1,1,2,2)); // 18 x8 reloaded to 2
    tbl.push_back(r(1,  0,1,  0,1,  0,1, 0,1,0,  0,1,0,0,0,0)); // 19 all x0
    tbl.push_back(r(1,  0,1,  0,0,  0,0, 0,0,0,  0,1,0,0,0,0)); // 20 x0 never pending
    tbl.push_back(r(1,  0,0,  0,0,  9,1, 0,1,0,  0,1,0,0,0,0)); // 21 MUL -> x9
    tbl.push_back(r(1,  9,1,  0,0, 10,1, 0,0,1,  1,0,0,0,0,0)); // 22 hazard + flush
    tbl.push_back(r(1, 10,1,  0,0,  0,0, 0,0,0,  0,1,0,0,0,0)); // 23 x10 not loaded
    tbl.push_back(r(1, 11,1,  0,0, 11,1, 0,0,0,  0,1,0,0,0,0)); // 24 rs==rd idle
    tbl.push_back(r(1, 11,1,  0,0,  0,0, 0,0,0,  0,1,1,0,2,0)); // 25 read x11
    tbl.push_back(r(1, 11,1,  0,0, 11,1, 0,0,0,  0,1,1,0,1,0)); // 26 rs==rd, old cnt
    tbl.push_back(r(1, 11,1,  0,0,  0,0, 0,0,0,  0,1,1,0,2,0)); // 27 new load applied
    tbl.push_back(r(1, 11,0,  0,0,  0,0, 0,0,0,  0,1,0,0,0,0)); // 28 unused source
    tbl.push_back(r(1,  0,0,  0,0, 12,1, 0,0,1,  0,0,0,0,0,0)); // 29 flush, no hazard
    tbl.push_back(r(1, 12,1,  0,0,  0,0, 0,0,0,  0,1,0,0,0,0)); // 30 x12 not loaded

    // Reset
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 10'd0);
    rst = 1'b0;

    // Table phase: one row per cycle starting from the clean state
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("row%0d", i), tbl[i].exp);
      $display("row %0d: stall=%0b issue=%0b dep=%0b%0b sel=%0d/%0d", i,
               hz.stall, hz.issue, hz.dep_src1, hz.dep_src2, hz.fwd_sel1, hz.fwd_sel2);
    end

    // Asynchronous reset while x9 has cnt = 4
    @(posedge clk); #1;
    drive(r(1, 0,0, 0,0, 9,1, 0,1,0, 0,0,0,0,0,0));          // MUL -> x9
    @(posedge clk); #1;
    v = r(1, 9,1, 0,0, 0,0, 0,0,0, 0,0,0,0,0,0);             // reader of x9
    drive(v);
    @(negedge clk);
    check("rst_seq_cnt5", 10'b1000000000);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq_cnt4", 10'b1000000000);
    #1 rst = 1'b1;
    #1 check("rst_async_drop", 10'b0100000000);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_next_cycle", 10'b0100000000);
    $display("reset sequence: x9 reader stall=%0b dep=%0b", hz.stall, hz.dep_src1);

    // Random phase against the ready-time model (state is clean: only a
    // non-writing reader has issued since reset)
    foreach (ready_at[i]) ready_at[i] = 0;
    for (int n = 0; n < 400; n++) begin
      int unsigned l;
      int unsigned r1;
      int unsigned r2;
      int unsigned rdr;
      logic raw1, raw2, waw, d1, d2, st, is;
      logic [2:0] s1, s2;

      @(posedge clk);
      now++;
      #1;
      v.valid = ($urandom_range(0, 9) != 0);
      v.rs1   = 5'($urandom_range(0, 7));
      v.u1    = $urandom_range(0, 3) != 0;
      v.rs2   = 5'($urandom_range(0, 7));
      v.u2    = $urandom_range(0, 1) != 0;
      v.rd    = 5'($urandom_range(0, 7));
      v.we    = $urandom_range(0, 9) < 7;
      v.ld    = $urandom_range(0, 3) == 0;
      v.mul   = $urandom_range(0, 3) == 0;
      v.flush = $urandom_range(0, 9) == 0;
      drive(v);
      @(negedge clk);

      l    = v.mul ? L_MUL : (v.ld ? L_LOAD : L_ALU);
      r1   = rem(v.rs1);
      r2   = rem(v.rs2);
      rdr  = rem(v.rd);
      raw1 = v.u1 && (r1 > FWD_WIN);
      raw2 = v.u2 && (r2 > FWD_WIN);
      d1   = v.valid && v.u1 && (r1 >= 1) && (r1 <= FWD_WIN);
      d2   = v.valid && v.u2 && (r2 >= 1) && (r2 <= FWD_WIN);
      s1   = d1 ? 3'(r1) : 3'd0;
      s2   = d2 ? 3'(r2) : 3'd0;
      waw  = v.we && (v.rd != 0) && (rdr > l);
      st   = v.valid && (raw1 || raw2 || waw);
      is   = v.valid && !st && !v.flush;
      check($sformatf("rand%0d", n), {st, is, d1, d2, s1, s2});

      if (is && v.we && (v.rd != 0)) begin
        ready_at[v.rd] = now + 1 + l;
        $display("rand %0d: issue write x%0d latency %0d", n, v.rd, l);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
